uart_arbiter: RTL

UART_ARBITER -- requirements
Module: uart_arbiter

---
 rtl/uart_arbiter_pkg.sv | 14 +
 rtl/uart_arbiter_rx_drain.sv | 38 +++
 rtl/uart_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_arbiter_pkg.sv
// Shared definitions for the uart arbiter slice: arbiter state encoding and
// default widths/limits used by the tx arbiter and the rx drain.
package uart_arbiter_pkg;

   localparam int DBIT_DEFAULT    = 8;
   localparam int TIMEOUT_DEFAULT = 16;
   localparam int CNT_W           = 8;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/uart_arbiter_rx_drain.sv
// Moves bytes from the uart rx FIFO into a one-entry valid/ready output stage,
// sustaining one byte per cycle when the consumer keeps rx_ready high.
module uart_rx_drain
   import uart_arbiter_pkg::*;
#(
   parameter int DBIT = DBIT_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DBIT-1:0] uart_rdata,
   input  logic            uart_rx_empty,
   output logic            uart_rd,
   output logic            rx_valid,
   output logic [DBIT-1:0] rx_data,
   input  logic            rx_ready
);

   logic            rxValid_q;
   logic [DBIT-1:0] rxData_q;

   // Pop whenever the output stage is empty or is being emptied this cycle.
   assign uart_rd  = !reset && !uart_rx_empty && (!rxValid_q || rx_ready);
   assign rx_valid = rxValid_q;
   assign rx_data  = rxData_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxValid_q <= 1'b0;
         rxData_q  <= '0;
      end else if (uart_rd) begin
         rxValid_q <= 1'b1;
         rxData_q  <= uart_rdata;
      end else if (rx_ready) begin
         rxValid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_arbiter.sv
// Two-requester packet arbiter in front of a uart tx FIFO, with a packet lock,
// round-robin fairness and an idle timeout; rx draining is delegated.
module uart_arbiter
   import uart_arbiter_pkg::*;
#(
   parameter int DBIT    = DBIT_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   input  logic [DBIT-1:0] req0_data,
   input  logic            req0_last,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [DBIT-1:0] req1_data,
   input  logic            req1_last,
   output logic            req1_ready,
   output logic            uart_wr,
   output logic [DBIT-1:0] uart_wdata,
   input  logic            uart_tx_full,
   output logic            uart_rd,
   input  logic [DBIT-1:0] uart_rdata,
   input  logic            uart_rx_empty,
   output logic            rx_valid,
   output logic [DBIT-1:0] rx_data,
   input  logic            rx_ready,
   output logic            owner,
   output logic            busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e       state_q;
   logic             owner_q;
   logic             rr_q;
   logic [CNT_W-1:0] cnt_q;

   logic ownerValid;
   logic ownerLast;
   logic inLock;
   logic xfer;
   logic winner;

   assign inLock     = (state_q == LOCK);
   assign ownerValid = owner_q ? req1_valid : req0_valid;
   assign ownerLast  = owner_q ? req1_last  : req0_last;
   assign xfer       = inLock && ownerValid && !uart_tx_full;

   // A lone requester wins outright; contention is settled by the rr pointer.
   assign winner = (req0_valid && req1_valid) ? rr_q : req1_valid;

   assign req0_ready = inLock && !owner_q && !uart_tx_full;
   assign req1_ready = inLock &&  owner_q && !uart_tx_full;
   assign uart_wr    = xfer && !reset;
   assign uart_wdata = owner_q ? req1_data : req0_data;
   assign owner      = owner_q;
   assign busy       = inLock;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  state_q <= LOCK;
                  owner_q <= winner;
                  cnt_q   <= '0;
               end
            end
            LOCK: begin
               // Stalls on tx_full hold the counter; only owner silence ages it.
               if (xfer) begin
                  cnt_q <= '0;
                  if (ownerLast) begin
                     state_q <= IDLE;
                     rr_q    <= ~owner_q;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE;
                  rr_q    <= ~owner_q;
                  cnt_q   <= '0;
               end else if (!ownerValid) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   uart_rx_drain #(
      .DBIT(DBIT)
   ) uRxDrain (
      .clk          (clk),
      .reset        (reset),
      .uart_rdata   (uart_rdata),
      .uart_rx_empty(uart_rx_empty),
      .uart_rd      (uart_rd),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready)
   );

endmodule
